// File: rtl/bk_add_arb_pkg.sv
// Shared types and helpers for the Brent-Kung adder arbiter.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package bk_add_arb_pkg;

    localparam int WIDTH_DEF = 12;

    typedef logic [WIDTH_DEF-1:0] operand_t;
    typedef logic [WIDTH_DEF:0]   sum_t;

    // Encoded as {v1, rsp_valid} so the state can be read straight off the valid flops.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ONE_S2 = 2'b01,
        ONE_S1 = 2'b10,
        FULL   = 2'b11
    } pipe_state_t;

    // Adder input bus layout: bit 2k = A[k], bit 2k+1 = B[k].
    function automatic logic [2*WIDTH_DEF-1:0] interleave(operand_t a, operand_t b);
        logic [2*WIDTH_DEF-1:0] r;
        r = '0;
        for (int k = 0; k < WIDTH_DEF; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_add_arbiter_if.sv
// Bundles the requester, adder and response signals of the adder arbiter.
// Latency: none (wires only).
// Backpressure: req_ready / rsp_ready carry the valid-ready handshakes.
// slave modport: the arbiter side; master modport: clients, adder and sink side.
interface bk_add_arbiter_if
    import bk_add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [2*WIDTH-1:0]       add_in;
    logic [WIDTH:0]           add_sum;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH:0]           rsp_sum;
    logic [ID_W-1:0]          rsp_id;
    pipe_state_t              pipe_state;   // debug view of {v1, rsp_valid}

    modport slave (
        input  req_valid, req_a, req_b, add_sum, rsp_ready,
        output req_ready, add_in, rsp_valid, rsp_sum, rsp_id, pipe_state
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, rsp_ready,
        input  req_ready, add_in, rsp_valid, rsp_sum, rsp_id, pipe_state
    );
endinterface

// File: rtl/bk_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins when enabled.
// Latency: combinational grant; ptr updates on the granting edge.
// Backpressure: en=0 forces a zero grant and freezes ptr.
// Ports: clk, rst (sync, active-high), req, en -> gnt (one-hot or zero), gnt_idx.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;

    always_comb begin : p_search
        int k;
        k       = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (en && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            // Explicit wrap keeps non-power-of-two NUM_REQ correct.
            ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/bk_add_arbiter.sv
// Shares one external WIDTH-bit adder among NUM_REQ round-robin requesters.
// Latency: accept at edge N gives rsp_valid after edge N+1; one result per cycle.
// Backpressure: rsp_ready=0 with both stages full stalls everything; req_ready drops.
// Ports: clk, rst (sync, active-high), bus (slave modport: req_*, add_in/add_sum, rsp_*).
// Optional BK_ADD_ARB_STATS_EN: adds stats_clr input and grant_cnt (16-bit saturating per requester).
module bk_add_arbiter
    import bk_add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    bk_add_arbiter_if.slave  bus
`ifdef BK_ADD_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               adv2;
    logic               s1_accept;

    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   a1_q, a1_d;
    logic [WIDTH-1:0]   b1_q, b1_d;
    logic [ID_W-1:0]    id1_q, id1_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH:0]     rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic [2*WIDTH-1:0] add_in_w;

    assign adv2      = v1_q && (!rsp_valid_q || bus.rsp_ready);
    assign s1_accept = !v1_q || adv2;

    // Gating with rst keeps req_ready low during the reset cycle.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .en      (s1_accept && !rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;

    // Operand stage: load on grant, otherwise empty when its content moves to S2.
    always_comb begin
        v1_d  = v1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        id1_d = id1_q;
        if (|gnt) begin
            v1_d  = 1'b1;
            id1_d = gnt_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    a1_d = bus.req_a[i*WIDTH +: WIDTH];
                    b1_d = bus.req_b[i*WIDTH +: WIDTH];
                end
            end
        end else if (adv2) begin
            v1_d = 1'b0;
        end
    end

    // Result stage: capture the adder output whenever S1 advances.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (adv2) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = bus.add_sum;
            rsp_id_d    = id1_q;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Adder bus is quiet when S1 holds nothing.
    always_comb begin
        add_in_w = '0;
        if (v1_q) begin
            for (int k = 0; k < WIDTH; k++) begin
                add_in_w[2*k]   = a1_q[k];
                add_in_w[2*k+1] = b1_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            id1_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            id1_q       <= id1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.add_in     = add_in_w;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.pipe_state = pipe_state_t'({v1_q, rsp_valid_q});

`ifdef BK_ADD_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    // Clear wins over a same-cycle grant; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (gnt[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif
endmodule

// File: doc/bk_add_arbiter.md
Name: bk_add_arbiter

Overview:
- Shares one combinational 12-bit Brent-Kung adder between NUM_REQ requesters.
- Round-robin arbitration; operands interleaved onto the adder's 24-bit input bus; 13-bit sum captured and returned with the requester ID.
- Two-stage pipeline: operand register, then result register. Sits between client blocks and the single adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 12, operand width; the adder bus is 2*WIDTH in, WIDTH+1 out
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a
- add_in  out  2*WIDTH  to adder; bit 2k = A[k], bit 2k+1 = B[k]
- add_sum  in  WIDTH+1  from adder; bit WIDTH is carry-out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_sum  out  WIDTH+1  registered sum
- rsp_id  out  ID_W  requester that issued rsp_sum
- Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Handshake: a transfer happens on any edge where valid && ready. req_ready never depends on the requester's own req_valid.
- Stage S1 holds v1, a1, b1 and id1. add_in is driven combinationally from a1/b1 at all times; it is 0 when v1=0.
- Stage S2 holds rsp_valid, rsp_sum and rsp_id.
- Advance conditions:
  - adv2 = v1 && (!rsp_valid || rsp_ready)
  - S1 can accept = !v1 || adv2
- Pipeline state, encoded as {v1, rsp_valid}:
  - EMPTY (00)
  - ONE_S1 (10)
  - ONE_S2 (01)
  - FULL (11)
  - FULL with rsp_ready=0 stalls both stages. All operand and ID registers hold.
- Arbitration:
  - When S1 can accept, grant the first requester with req_valid=1, searching from pointer ptr and wrapping modulo NUM_REQ.
  - req_ready[g]=1 for that requester only.
  - On a grant, ptr <= g+1, wrapping to 0 after NUM_REQ-1. With no grant, ptr holds.
- Latency: an accept at edge N gives rsp_valid=1 after edge N+1 (2 cycles, zero stalls). Throughput is one result per cycle.
- Simultaneous S2 drain and S1 load in the same cycle is legal and loses nothing.
- The sum is the full WIDTH+1 bits: max+max = 0x1FFE for WIDTH=12. No truncation.
- Reset values:
  - v1=0, rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0, req_ready=0, add_in=0
  - Reset mid-operation discards in-flight S1 and S2 data with no response.
  - req_ready is 0 during the rst cycle.
- Requester rules:
  - A requester must hold req_a/req_b stable while req_valid=1 and not accepted.
  - Dropping req_valid without acceptance is tolerated: that request is simply not granted.

Optional Feature:
- Macro: BK_ADD_ARB_STATS_EN.
- When defined, adds:
  - output grant_cnt  (NUM_REQ*16): per-requester 16-bit saturating grant counters. Increment on accept; hold at 0xFFFF.
  - input stats_clr (1): synchronous clear of all counters; has priority over a same-cycle increment.
  - All counters reset to 0.
- When undefined: neither port exists and there are no counter flops. Core behaviour is identical.

Decomposition:
- Package bk_add_arb_pkg:
  - WIDTH_DEF=12
  - typedef operand_t (WIDTH bits)
  - typedef sum_t (WIDTH+1 bits)
  - function interleave(a, b) returning the 2*WIDTH bus
  - typedef pipe_state_t {EMPTY, ONE_S1, ONE_S2, FULL} for debug visibility
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, enable, clk, rst
  - outputs: one-hot grant and encoded index
  - owns ptr
- The top instantiates rr_arbiter and holds S1/S2. The adder is external.

Test Plan:
- Single request, bench adder model attached: req0 a=0x7FF, b=0x001, rsp_ready=1 → add_in=interleave(0x7FF,0x001); 2 cycles later rsp_valid=1, rsp_sum=0x0800, rsp_id=0.
- Carry-out: a=0xFFF, b=0xFFF on req2 → rsp_sum=0x1FFE, rsp_id=2.
- Fairness: all 4 requesters valid continuously for 8 grants from reset → grant order 0,1,2,3,0,1,2,3; one result per cycle.
- Backpressure: 3 back-to-back accepts, rsp_ready=0 for 5 cycles → at most 2 accepted (S1+S2 full), then req_ready=0 and rsp_sum/rsp_id hold; releasing rsp_ready drains in order with no loss or duplication.
- Reset mid-flight: rst=1 with FULL state → next cycle rsp_valid=0, ptr=0; first post-reset grant goes to the lowest valid index.
- Stats (BK_ADD_ARB_STATS_EN): 70000 grants to req1 → grant_cnt[1]=0xFFFF; stats_clr coincident with a grant → 0.
